dmem_dma_ctrl: RTL
==================

// Module: dmem_dma_ctrl
// PURPOSE
//  Byte-copy DMA engine and port arbiter for the single-port 8x256 data memory.
//  - Sits between the core's load/store port and the data memory.
//  - Copies len bytes from src_addr to dst_addr in the background.
//  - The core always has priority; the DMA uses only cycles the core leaves idle.
//  - Memory model: reads are combinational; writes commit on posedge clk.
// PARAMETERS
//  ADDR_W  8  memory address width; addresses wrap modulo 2**ADDR_W
//  DATA_W  8  memory data width
// PORTS
//  clk         in   1       clock
//  Reset       in   1       reset: synchronous, active-high
//  start       in   1       1-cycle pulse; launch transfer (ignored while busy)
//  src_addr    in   ADDR_W  source base; sampled on accepted start
//  dst_addr    in   ADDR_W  destination base; sampled on accepted start
//  len         in   ADDR_W  byte count; 0 = no-op; sampled on accepted start
//  fill_en     in   1       fill mode select; sampled on start (see CONFIGURATION)
//  fill_data   in   DATA_W  fill byte; sampled on start
//  busy        out  1       high from the cycle after an accepted start until done
//  done        out  1       1-cycle pulse when the transfer completes
//  core_req    in   1       core accesses memory this cycle
//  core_we     in   1       core write enable; qualified by core_req
//  core_addr   in   ADDR_W  core address
//  core_wdata  in   DATA_W  core write data
//  core_rdata  out  DATA_W  = mem_rdata; combinational, valid while core_req
//  mem_we      out  1       to memory write_en
//  mem_addr    out  ADDR_W  to memory DataAddress
//  mem_wdata   out  DATA_W  to memory data_in
//  mem_rdata   in   DATA_W  from memory DataOut
// BEHAVIOUR
//  - States: IDLE, RD, WR, FIN.
//  - Reset forces IDLE. busy=0, done=0, mem_we=0. Internal counters and buffer cleared.
//  - IDLE:
//    - start with len!=0: latch src, dst and len; go to RD.
//    - start with len==0: go to FIN; the transfer does no memory access.
//  - RD: if !core_req, drive mem_addr=src and capture mem_rdata into buf; go to WR.
//    - If core_req, hold in RD.
//  - WR: if !core_req, drive mem_we=1, mem_addr=dst, mem_wdata=buf.
//    - Then src++ and dst++ (modulo 256) and cnt--.
//    - Go to FIN if cnt reaches 0, otherwise to RD.
//    - If core_req, hold in WR; buf is retained.
//  - FIN: done=1 for exactly one cycle, busy drops in the same cycle; go to IDLE.
//  - Mux: core_req=1 gives the core mem_we=core_we, mem_addr=core_addr, mem_wdata=core_wdata.
//    - The core is never stalled and there is no core-side handshake.
//    - When neither core nor DMA drives the bus: mem_we=0 and mem_addr=0.
//  - Latency with no contention: 2*len+1 cycles from the accepted start to the done pulse.
//    - Each cycle of core_req during RD or WR adds one cycle.
//  - Overlap: strict forward byte-by-byte copy; overlapping ranges follow those semantics.
//  - Addresses wrap 0xFF->0x00. A source or destination range may cross the wrap point.
//  - start while busy is ignored; the latched parameters do not change.
//  - Reset mid-transfer aborts the transfer. No write is issued in the reset cycle and done is not pulsed.
// CONFIGURATION
//  - Macro DMEM_DMA_FILL_EN:
//    - Defined: fill_en=1 at start makes each WR write fill_data (latched at start).
//      RD cycles are skipped, so latency is len+1 cycles.
//    - Undefined: fill_en and fill_data are ignored and the block always copies.
//  - The ports exist in both builds.
// STRUCTURE
//  - Package dmem_pkg holds:
//    - state enum (IDLE, RD, WR, FIN)
//    - DMEM_ADDR_W=8, DMEM_DATA_W=8, DMEM_DEPTH=256
//  - Sub-module dmem_port_mux: combinational core/DMA select onto mem_* signals.
//  - FSM, counters and buffer live in the top module.
// TESTING
//  1. Preload mem[0x10..0x13]=A1,B2,C3,D4. start src=10 dst=40 len=4, no core_req.
//     -> mem[0x40..0x43]=A1..D4; done pulses exactly 9 cycles after the start.
//  2. Same copy with core_req held high for 3 cycles mid-transfer (core writes 0x55 to 0x80).
//     -> core write lands in that cycle; copy intact; done delayed by 3 cycles.
//  3. Wrap: src=FE dst=02 len=4 with mem[FE,FF,00,01]=1,2,3,4.
//     -> mem[02..05]=1,2,3,4.
//  4. Edge cases: start with len=0 -> done 1 cycle later, no mem_we.
//     A second start while busy -> ignored; the first copy completes unchanged.
//  5. Reset asserted while in WR -> next cycle busy=0, done=0, mem_we=0. The destination
//     byte is not written and the FSM is in IDLE.
//  6. With DMEM_DMA_FILL_EN: start fill_en=1 fill_data=0x7E dst=20 len=3.
//     -> mem[20..22]=7E; done 4 cycles after the start.
//     Without the macro the same stimulus performs a copy.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths and FSM state encoding for the data-memory DMA block.
package dmem_pkg;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_DEPTH = 256;
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
endpackage

// File: rtl/dmem_port_mux.sv
// dmem_port_mux: core-priority selection of core or DMA onto the memory port.
module dmem_port_mux
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);
    always_comb begin
        mem_we = core_req ? core_we : dma_req & dma_we;
        mem_addr = core_req ? core_addr : dma_req ? dma_addr : '0;
        mem_wdata = core_req ? core_wdata : dma_wdata;
    end
endmodule

// File: rtl/dmem_dma_ctrl.sv
// dmem_dma_ctrl: background byte-copy DMA sharing the data memory with the core.
// Build macro DMEM_DMA_FILL_EN enables fill mode (write fill_data, no reads).
module dmem_dma_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DATA_W = DMEM_DATA_W
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] len,
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
`ifdef DMEM_DMA_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif
    state_t state;
    logic [ADDR_W-1:0] src, dst, cnt;
    logic [DATA_W-1:0] data_buf;
    logic fill_mode;
    logic dma_req;
    // Gating with Reset keeps an aborted transfer from writing in the reset cycle.
    assign dma_req = !Reset && (state == RD || state == WR);
    assign core_rdata = mem_rdata;
    dmem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .dma_req(dma_req), .dma_we(state == WR), .dma_addr(state == RD ? src : dst),
        .dma_wdata(data_buf), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );
    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            cnt <= '0;
            data_buf <= '0;
            fill_mode <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        src <= src_addr;
                        dst <= dst_addr;
                        cnt <= len;
                        // Fill mode preloads the buffer once and never visits RD.
                        data_buf <= fill_data;
                        fill_mode <= FILL && fill_en;
                        busy <= len != '0;
                        done <= len == '0;
                        state <= len == '0 ? FIN : (FILL && fill_en) ? WR : RD;
                    end
                end
                RD: if (!core_req) begin
                    data_buf <= mem_rdata;
                    state <= WR;
                end
                WR: if (!core_req) begin
                    src <= src + 1'b1;
                    dst <= dst + 1'b1;
                    cnt <= cnt - 1'b1;
                    if (cnt == ADDR_W'(1)) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= FIN;
                    end else begin
                        state <= fill_mode ? WR : RD;
                    end
                end
                default: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
